// File: rtl/mwave_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mwave_timer_ctrl
// Brief    : Microwave cook timer: keypad MM:SS entry, 1 Hz BCD countdown,
//            door-interlocked magnetron gating. Optional MWAVE_QUICK_START_EN
//            enables +30 s quick start.
// Revision : 1.0 - initial release
// ============================================================================
module mwave_timer_ctrl (
    input  logic        clk,
    input  logic        clrn,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_closed,
    output logic [15:0] digits,
    output logic        magnetron_on,
    output logic        done,
    output logic [1:0]  state
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COOKING = 2'd1;
    localparam logic [1:0] c_PAUSED  = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

`ifdef MWAVE_QUICK_START_EN
    localparam bit c_QUICK = 1'b1;
`else
    localparam bit c_QUICK = 1'b0;
`endif

    logic [1:0]  r_state;
    logic [15:0] r_digits;
    logic        r_magnetron_on;
    logic        r_done;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_digits_nxt;
    logic [15:0] w_dec;
    logic [15:0] w_add30;
    logic        w_mag_nxt;
    logic        w_done_nxt;

    // One-second borrow chain; sec_tens wraps to 5, other digits to 9.
    function automatic logic [15:0] f_bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        logic       b;
        {mt, mu, st, su} = v;
        b = 1'b0;
        if (su == 4'd0) begin su = 4'd9; b = 1'b1; end
        else            su = su - 4'd1;
        if (b) begin
            if (st == 4'd0) st = 4'd5;
            else begin st = st - 4'd1; b = 1'b0; end
        end
        if (b) begin
            if (mu == 4'd0) mu = 4'd9;
            else begin mu = mu - 4'd1; b = 1'b0; end
        end
        if (b) mt = mt - 4'd1;
        return {mt, mu, st, su};
    endfunction

    // +30 s with sec_tens carrying at 6; minute overflow saturates to 99:59.
    function automatic logic [15:0] f_bcd_add30(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        logic [4:0] s;
        logic       sat;
        {mt, mu, st, su} = v;
        sat = 1'b0;
        s   = {1'b0, st} + 5'd3;
        if (s >= 5'd6) begin
            s  = s - 5'd6;
            st = s[3:0];
            if (mu == 4'd9) begin
                mu = 4'd0;
                if (mt == 4'd9) sat = 1'b1;
                else            mt = mt + 4'd1;
            end else begin
                mu = mu + 4'd1;
            end
        end else begin
            st = s[3:0];
        end
        return sat ? 16'h9959 : {mt, mu, st, su};
    endfunction

    assign w_dec   = f_bcd_dec(r_digits);
    assign w_add30 = f_bcd_add30(r_digits);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state        <= c_IDLE;
            r_digits       <= 16'h0000;
            r_magnetron_on <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_digits       <= w_digits_nxt;
            r_magnetron_on <= w_mag_nxt;
            r_done         <= w_done_nxt;
        end
    end

    // Each branch chain encodes the event priority; an ignored event falls through.
    always_comb begin
        w_state_nxt  = r_state;
        w_digits_nxt = r_digits;
        case (r_state)
            c_IDLE: begin
                if (stop_clear) begin
                    w_digits_nxt = 16'h0000;
                end else if (start && door_closed && ((r_digits != 16'h0000) || c_QUICK)) begin
                    w_state_nxt = c_COOKING;
                    if (r_digits == 16'h0000) w_digits_nxt = 16'h0030;
                end else if (key_valid && (key_code <= 4'd9)) begin
                    w_digits_nxt = {r_digits[11:0], key_code};
                end
            end
            c_COOKING: begin
                if (stop_clear || !door_closed) begin
                    w_state_nxt = c_PAUSED;
                end else if (start && c_QUICK) begin
                    w_digits_nxt = w_add30;
                end else if (tick) begin
                    w_digits_nxt = w_dec;
                    if (w_dec == 16'h0000) w_state_nxt = c_DONE;
                end
            end
            c_PAUSED: begin
                if (stop_clear) begin
                    w_state_nxt  = c_IDLE;
                    w_digits_nxt = 16'h0000;
                end else if (start && door_closed) begin
                    w_state_nxt = c_COOKING;
                end
            end
            default: begin
                w_digits_nxt = 16'h0000;
                if (stop_clear || !door_closed) w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_mag_nxt  = (w_state_nxt == c_COOKING);
        w_done_nxt = (w_state_nxt == c_DONE);
    end

    assign state        = r_state;
    assign digits       = r_digits;
    assign magnetron_on = r_magnetron_on;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: doc/mwave_timer_ctrl.md
# mwave_timer_ctrl

Cook-timer controller for the microwave front panel. It accepts keypad digits into an MM:SS BCD register and sequences a 4-digit BCD countdown from a 1 Hz tick. It gates the magnetron enable through an IDLE/COOKING/PAUSED/DONE state machine that honours the door interlock. It sits between the keypad decoder and the display/magnetron drivers.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse, once per second, synchronous to clk
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  keypad value; 0-9 are digits, 10-15 are ignored
- start  in  1  one-cycle start/resume strobe
- stop_clear  in  1  one-cycle stop/cancel strobe
- door_closed  in  1  level; 1 = door latched
- digits  out  16  BCD {min_tens, min_units, sec_tens, sec_units}
- magnetron_on  out  1  high only in COOKING
- done  out  1  high only in DONE
- state  out  2  IDLE=0, COOKING=1, PAUSED=2, DONE=3

## Operation
- All outputs are registered. Every output reaches its new value on the clk edge that samples the causing input.
- Per-cycle event priority: stop_clear > door open (door_closed=0) > start > tick > key_valid. Only the highest-priority applicable event acts in a cycle.
- IDLE:
  - key_valid with key_code<=9 gives digits <= {digits[11:0], key_code}. The oldest digit is dropped after 4 entries. Codes 10-15 leave digits unchanged.
  - start with door_closed=1 and digits!=0 goes to COOKING, digits unchanged.
  - start with digits==0 or door open is ignored, except under QUICK_START (see Configuration).
  - stop_clear sets digits to 0.
- COOKING:
  - Each tick decrements digits as a borrow chain:
    - sec_units 0 wraps to 9 and borrows.
    - sec_tens 0 wraps to 5 and borrows.
    - min_units 0 wraps to 9 and borrows.
    - min_tens decrements.
  - Entered sec_tens values 6-9 are legal and count down normally (00:90 goes to 00:89).
  - If the decremented value is 0000, the same edge moves to DONE.
  - Door open or stop_clear goes to PAUSED with digits frozen. key_valid is ignored.
- PAUSED:
  - start with door_closed=1 goes to COOKING.
  - stop_clear goes to IDLE and sets digits to 0.
  - tick and key_valid are ignored.
- DONE:
  - digits=0000 and done=1.
  - stop_clear or door open goes to IDLE.
  - start, tick, and key are ignored.
- Decrementing from 0000 is unreachable. COOKING is never entered with digits=0.

## Timing
- Reset (clrn=0, async): state=IDLE, digits=16'h0000, magnetron_on=0, done=0. The block stays there while clrn is low.
- Reset mid-cook clears everything immediately, without waiting for clk.
- Latency:
  - start to magnetron_on=1 is one edge.
  - The final tick reaching 0000 sets magnetron_on=0 and done=1 on the same edge.
  - Door open drops magnetron_on on the next edge.
- tick coincident with stop_clear or door open in COOKING: no decrement.
- tick coincident with start in PAUSED: resume only, no decrement on that edge.
- key_valid coincident with start in IDLE: start acts and the key is discarded.

## Configuration
- MWAVE_QUICK_START_EN defined:
  - In IDLE, start with door_closed=1 and digits==0 loads 00:30 and enters COOKING on the same edge.
  - In COOKING, start adds 30 s to the current time using BCD add with carry (sec_tens carries at 6), saturating at 99:59.
- MWAVE_QUICK_START_EN undefined: both of those start events are ignored.

## Test plan
- Reset: hold clrn=0 mid-COOKING at 01:23 -> immediately state=0, digits=0000, magnetron_on=0, done=0.
- Entry: keys 1,2,3,4,5 then key 12 -> digits=16'h2345. Then stop_clear -> 0000.
- Countdown: load 01:00, start, 2 ticks -> digits=0059 then 0058, magnetron_on=1 throughout. Load 00:02, start, 2 ticks -> the second tick gives digits=0000, state=DONE, done=1, magnetron_on=0 on the same edge.
- Door interlock: COOKING at 00:10, door_closed=0 with a coincident tick -> PAUSED at 00:10, magnetron_on=0. Start while the door is open -> stays PAUSED. Door closed then start -> COOKING at 00:10.
- Priority and cancel: COOKING, stop_clear+start+tick in the same cycle -> PAUSED, digits unchanged. stop_clear again -> IDLE, 0000.
- Quick start (macro on):
  - Start from IDLE at 0000 -> COOKING at 0030.
  - Start at 00:45 -> 01:15.
  - Start at 99:50 -> 99:59.
- Macro off: start at 0000 -> stays IDLE.
